// File: rtl/commit_arbiter.sv
// rtl/commit_arbiter.sv - round-robin merge of execute-unit results into one registered commit port
// Also keeps retired-instruction and retired-thread counters for the CSR unit.
module commit_arbiter #(
  parameter int NUM_REQS    = 5,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int REQ_BITS    = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  output logic [NUM_REQS-1:0]             req_ready,
  input  logic [NUM_REQS*NW_BITS-1:0]     req_wid,
  input  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask,
  input  logic [NUM_REQS*32-1:0]          req_PC,
  input  logic [NUM_REQS*NR_BITS-1:0]     req_rd,
  input  logic [NUM_REQS-1:0]             req_wb,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [NW_BITS-1:0]              wb_wid,
  output logic [NUM_THREADS-1:0]          wb_tmask,
  output logic [31:0]                     wb_PC,
  output logic [NR_BITS-1:0]              wb_rd,
  output logic                            wb_wb,
  output logic [NUM_THREADS*32-1:0]       wb_data,
  output logic [63:0]                     commit_count,
  output logic [63:0]                     commit_thread_count
);

  localparam logic [REQ_BITS:0] NUM_REQS_W = (REQ_BITS+1)'(NUM_REQS);

  logic [REQ_BITS-1:0]       rr_ptr;
  logic [REQ_BITS-1:0]       next_ptr;
  logic [REQ_BITS:0]         cand;
  logic [REQ_BITS-1:0]       grant_idx;
  logic                      grant_any;
  logic [NUM_REQS-1:0]       grant;
  logic                      stage_en;
  logic                      commit_fire;
  logic [63:0]               tmask_pop;

  logic [NW_BITS-1:0]        sel_wid;
  logic [NUM_THREADS-1:0]    sel_tmask;
  logic [31:0]               sel_PC;
  logic [NR_BITS-1:0]        sel_rd;
  logic                      sel_wb;
  logic [NUM_THREADS*32-1:0] sel_data;

  assign stage_en    = !wb_valid || wb_ready;
  assign commit_fire = wb_valid && wb_ready;
  assign req_ready   = {NUM_REQS{stage_en && !reset}} & grant;
  assign next_ptr    = (grant_idx == REQ_BITS'(NUM_REQS-1)) ? '0 : grant_idx + REQ_BITS'(1);

  // Circular priority search starting at rr_ptr; first valid requester wins.
  always_comb begin
    cand      = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    grant     = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = {1'b0, rr_ptr} + (REQ_BITS+1)'(k);
      if (cand >= NUM_REQS_W) cand = cand - NUM_REQS_W;
      if (!grant_any && req_valid[cand[REQ_BITS-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[REQ_BITS-1:0];
      end
    end
    for (int k = 0; k < NUM_REQS; k++) begin
      grant[k] = grant_any && (grant_idx == REQ_BITS'(k));
    end
  end

  always_comb begin
    sel_wid   = '0;
    sel_tmask = '0;
    sel_PC    = '0;
    sel_rd    = '0;
    sel_wb    = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (grant[k]) begin
        sel_wid   = req_wid[k*NW_BITS +: NW_BITS];
        sel_tmask = req_tmask[k*NUM_THREADS +: NUM_THREADS];
        sel_PC    = req_PC[k*32 +: 32];
        sel_rd    = req_rd[k*NR_BITS +: NR_BITS];
        sel_wb    = req_wb[k];
        sel_data  = req_data[k*NUM_THREADS*32 +: NUM_THREADS*32];
      end
    end
  end

  always_comb begin
    tmask_pop = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      tmask_pop = tmask_pop + 64'(wb_tmask[t]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid            <= 1'b0;
      wb_wid              <= '0;
      wb_tmask            <= '0;
      wb_PC               <= '0;
      wb_rd               <= '0;
      wb_wb               <= 1'b0;
      wb_data             <= '0;
      rr_ptr              <= '0;
      commit_count        <= '0;
      commit_thread_count <= '0;
    end else begin
      if (stage_en) begin
        wb_valid <= grant_any;
        if (grant_any) begin
          wb_wid   <= sel_wid;
          wb_tmask <= sel_tmask;
          wb_PC    <= sel_PC;
          wb_rd    <= sel_rd;
          wb_wb    <= sel_wb;
          wb_data  <= sel_data;
          rr_ptr   <= next_ptr;
        end
      end
      if (commit_fire) begin
        commit_count        <= commit_count + 64'd1;
        commit_thread_count <= commit_thread_count + tmask_pop;
      end
    end
  end

endmodule

// File: tb/tb_commit_arbiter.sv
// tb/tb_commit_arbiter.sv - directed self-checking bench for commit_arbiter
module tb_commit_arbiter;

  localparam int NR = 5;
  localparam int NT = 4;
  localparam int NW = 2;
  localparam int RB = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*NW-1:0]     req_wid;
  logic [NR*NT-1:0]     req_tmask;
  logic [NR*32-1:0]     req_PC;
  logic [NR*RB-1:0]     req_rd;
  logic [NR-1:0]        req_wb;
  logic [NR*NT*32-1:0]  req_data;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [NW-1:0]        wb_wid;
  logic [NT-1:0]        wb_tmask;
  logic [31:0]          wb_PC;
  logic [RB-1:0]        wb_rd;
  logic                 wb_wb;
  logic [NT*32-1:0]     wb_data;
  logic [63:0]          commit_count;
  logic [63:0]          commit_thread_count;

  int n_pass = 0;
  int n_total = 0;

  commit_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wid(req_wid), .req_tmask(req_tmask), .req_PC(req_PC),
    .req_rd(req_rd), .req_wb(req_wb), .req_data(req_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wid(wb_wid), .wb_tmask(wb_tmask), .wb_PC(wb_PC),
    .wb_rd(wb_rd), .wb_wb(wb_wb), .wb_data(wb_data),
    .commit_count(commit_count), .commit_thread_count(commit_thread_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [NT*32-1:0] mk_data(input logic [31:0] pc);
    logic [NT*32-1:0] d;
    for (int t = 0; t < NT; t++) d[t*32 +: 32] = pc + 32'(t);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [NW-1:0] wid, input logic [NT-1:0] tm,
                         input logic [31:0] pc, input logic [RB-1:0] rd, input logic wb);
    req_wid[i*NW +: NW]           = wid;
    req_tmask[i*NT +: NT]         = tm;
    req_PC[i*32 +: 32]            = pc;
    req_rd[i*RB +: RB]            = rd;
    req_wb[i]                     = wb;
    req_data[i*NT*32 +: NT*32]    = mk_data(pc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_wid = '0; req_tmask = '0; req_PC = '0;
    req_rd = '0; req_wb = '0; req_data = '0; wb_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    wb_ready = 1'b1;
    tick();
    chk("reset_req_ready", 128'(req_ready), 128'(0));
    chk("reset_wb_valid", 128'(wb_valid), 128'(0));
    chk("reset_count", 128'(commit_count), 128'(0));
    chk("reset_thread_count", 128'(commit_thread_count), 128'(0));
    chk("reset_wb_PC", 128'(wb_PC), 128'(0));
    req_valid = '0;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 2'd1, 4'hF, 32'h8000_0010, 5'd5, 1'b1);
    req_valid = 5'b00010;
    #1;
    chk("single_req_ready", 128'(req_ready), 128'(5'b00010));
    tick();
    req_valid = '0;
    chk("single_wb_valid", 128'(wb_valid), 128'(1));
    chk("single_wb_wid", 128'(wb_wid), 128'(1));
    chk("single_wb_PC", 128'(wb_PC), 128'(32'h8000_0010));
    chk("single_wb_rd", 128'(wb_rd), 128'(5));
    chk("single_wb_tmask", 128'(wb_tmask), 128'(4'hF));
    chk("single_wb_wb", 128'(wb_wb), 128'(1));
    chk("single_wb_data", 128'(wb_data), 128'(mk_data(32'h8000_0010)));
    chk("single_count_before", 128'(commit_count), 128'(0));
    tick();
    chk("single_wb_valid_after", 128'(wb_valid), 128'(0));
    chk("single_count", 128'(commit_count), 128'(1));
    chk("single_thread_count", 128'(commit_thread_count), 128'(4));
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, NW'(i), 4'hF, 32'h100 + 32'(i*16), RB'(i), 1'b1);
    req_valid = '1;
    for (int n = 0; n < 7; n++) begin
      tick();
      chk($sformatf("rr_order_%0d", n), 128'(wb_PC), 128'(32'h100 + 32'((n % NR) * 16)));
      chk($sformatf("rr_valid_%0d", n), 128'(wb_valid), 128'(1));
      if (n == 4) chk("rr_ptr_wrap", 128'(dut.rr_ptr), 128'(0));
    end
    req_valid = '0;
    chk("rr_count", 128'(commit_count), 128'(6));
    chk("rr_thread_count", 128'(commit_thread_count), 128'(24));
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 2'd2, 4'h3, 32'h2000, 5'd7, 1'b1);
    set_req(3, 2'd3, 4'h1, 32'h3000, 5'd9, 1'b1);
    req_valid = 5'b01001;
    wb_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_req_ready_%0d", c), 128'(req_ready), 128'(0));
      chk($sformatf("bp_wb_PC_%0d", c), 128'(wb_PC), 128'(32'h2000));
      chk($sformatf("bp_wb_valid_%0d", c), 128'(wb_valid), 128'(1));
      chk($sformatf("bp_count_%0d", c), 128'(commit_count), 128'(0));
      tick();
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(req_ready), 128'(5'b01000));
    tick();
    req_valid = '0;
    chk("bp_fpu_PC", 128'(wb_PC), 128'(32'h3000));
    chk("bp_fpu_rd", 128'(wb_rd), 128'(9));
    chk("bp_count", 128'(commit_count), 128'(1));
    chk("bp_thread_count", 128'(commit_thread_count), 128'(2));
  endtask

  task automatic test_pointer_skip();
    do_reset();
    set_req(0, 2'd0, 4'hF, 32'h4000, 5'd1, 1'b1);
    set_req(2, 2'd1, 4'hF, 32'h4200, 5'd2, 1'b1);
    req_valid = 5'b00100;
    tick();
    chk("skip_setup_ptr", 128'(dut.rr_ptr), 128'(3));
    req_valid = 5'b00101;
    #1;
    chk("skip_alu_ready", 128'(req_ready), 128'(5'b00001));
    tick();
    req_valid = 5'b00100;
    chk("skip_alu_PC", 128'(wb_PC), 128'(32'h4000));
    chk("skip_ptr_1", 128'(dut.rr_ptr), 128'(1));
    chk("skip_csr_ready", 128'(req_ready), 128'(5'b00100));
    tick();
    req_valid = '0;
    chk("skip_csr_PC", 128'(wb_PC), 128'(32'h4200));
    chk("skip_ptr_3", 128'(dut.rr_ptr), 128'(3));
  endtask

  task automatic test_partial_mask();
    do_reset();
    set_req(4, 2'd3, 4'h5, 32'h5000, 5'd0, 1'b0);
    req_valid = 5'b10000;
    tick();
    req_valid = '0;
    chk("pm_wb_valid", 128'(wb_valid), 128'(1));
    chk("pm_wb_wb", 128'(wb_wb), 128'(0));
    chk("pm_wb_tmask", 128'(wb_tmask), 128'(4'h5));
    tick();
    chk("pm_thread_count", 128'(commit_thread_count), 128'(2));
    chk("pm_count", 128'(commit_count), 128'(1));
    set_req(0, 2'd0, 4'h0, 32'h5100, 5'd3, 1'b1);
    req_valid = 5'b00001;
    tick();
    req_valid = '0;
    chk("zm_wb_tmask", 128'(wb_tmask), 128'(0));
    tick();
    chk("zm_count", 128'(commit_count), 128'(2));
    chk("zm_thread_count", 128'(commit_thread_count), 128'(2));
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_req(0, 2'd1, 4'h7, 32'h6000, 5'd4, 1'b1);
    set_req(1, 2'd2, 4'hF, 32'h6100, 5'd6, 1'b1);
    req_valid = 5'b00001;
    tick();
    req_valid = 5'b00010;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    req_valid = '0;
    chk("mid_pre_valid", 128'(wb_valid), 128'(1));
    chk("mid_pre_count", 128'(commit_count), 128'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_wb_valid", 128'(wb_valid), 128'(0));
    chk("mid_count", 128'(commit_count), 128'(0));
    chk("mid_thread_count", 128'(commit_thread_count), 128'(0));
    chk("mid_ptr", 128'(dut.rr_ptr), 128'(0));
    tick();
    reset = 1'b0;
    wb_ready = 1'b1;
    tick();
    chk("mid_no_stale", 128'(wb_valid), 128'(0));
    tick();
    chk("mid_count_after", 128'(commit_count), 128'(0));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_wid = '0; req_tmask = '0; req_PC = '0;
    req_rd = '0; req_wb = '0; req_data = '0; wb_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_partial_mask();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
